// File: rtl/machine_seq_ctrl_if.sv
// Host-side handshake and result bundle for machine_seq_ctrl.
// master = host/test logic, slave = the sequencing controller.
interface machine_seq_ctrl_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned LW = 4,
    parameter int unsigned CW = 4
);
    logic          start;
    logic          abort;
    logic [N-1:0]  pattern;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [N-1:0]  hit_mask;
    logic [CW-1:0] hit_count;
    logic          state_err;

    modport master (
        output start, abort, pattern, len,
        input  busy, done, hit_mask, hit_count, state_err
    );

    modport slave (
        input  start, abort, pattern, len,
        output busy, done, hit_mask, hit_count, state_err
    );
endinterface

// File: rtl/machine_seq_ctrl.sv
// Sequencing controller: clears the serial machine, shifts a pattern into x and records F per bit.
// Optional illegal-state checking is enabled by defining STATE_CHECK_EN.
module machine_seq_ctrl #(
    parameter int unsigned N         = 8,
    parameter int unsigned LW        = 4,
    parameter int unsigned CW        = 4,
    parameter int unsigned MAX_STATE = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    machine_seq_ctrl_if.slave   host,
    output logic                m_reset_o,
    output logic                x_out_o,
    input  logic                f_in_i,
    input  logic [2:0]          s_in_i
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] NLen = LW'(N);

    typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  pat_q;
    logic [N-1:0]  mask_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] last_q;
    logic [CW-1:0] cnt_q;
    logic          m_reset_q;
    logic          x_q;
    logic          busy_q;
    logic          done_q;

    logic [LW-1:0] len_eff;
    logic [IW-1:0] cap_idx;
    logic          accept;
    logic          abort_run;
    logic          cap_en;

    always_comb begin
        len_eff   = (host.len > NLen) ? NLen : host.len;
        accept    = (state_q == StIdle) && host.start && !host.abort && (host.len != '0);
        abort_run = host.abort &&
                    ((state_q == StClr) || (state_q == StRun) || (state_q == StDrain));
        // F reflects the bit applied in the previous cycle; the abort edge captures nothing.
        cap_en    = !host.abort &&
                    (((state_q == StRun) && (idx_q != '0)) || (state_q == StDrain));
        cap_idx   = (state_q == StDrain) ? idx_q : idx_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            m_reset_q <= 1'b1;
            x_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cap_en) begin
                mask_q[cap_idx] <= f_in_i;
                if (f_in_i && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (abort_run) begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                m_reset_q <= 1'b1;
                x_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            pat_q   <= host.pattern;
                            last_q  <= IW'(len_eff - 1'b1);
                            idx_q   <= '0;
                            mask_q  <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StClr;
                        end
                    end
                    StClr: begin
                        state_q   <= StRun;
                        m_reset_q <= 1'b0;
                        x_q       <= pat_q[0];
                    end
                    StRun: begin
                        if (idx_q == last_q) begin
                            state_q <= StDrain;
                            x_q     <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            x_q   <= pat_q[idx_q + 1'b1];
                        end
                    end
                    StDrain: begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        m_reset_q <= 1'b1;
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef STATE_CHECK_EN
    localparam logic [2:0] MaxS = 3'(MAX_STATE);
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (((state_q == StRun) || (state_q == StDrain)) && (s_in_i > MaxS)) begin
            err_q <= 1'b1;
        end
    end

    assign host.state_err = err_q;
`else
    logic unused_s;
    assign unused_s       = ^{s_in_i, 3'(MAX_STATE)};
    assign host.state_err = 1'b0;
`endif

    assign m_reset_o      = m_reset_q;
    assign x_out_o        = x_q;
    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.hit_mask  = mask_q;
    assign host.hit_count = cnt_q;
endmodule

// File: tb/tb_machine_seq_ctrl.sv
// Self-checking bench for machine_seq_ctrl: two instances (CW=4 and CW=2) share stimulus;
// results are predicted from the F values the bench presents in each sampling window.
module tb_machine_seq_ctrl;
`ifdef STATE_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    machine_seq_ctrl_if #(.N(8), .LW(4), .CW(4)) hif ();
    machine_seq_ctrl_if #(.N(8), .LW(4), .CW(2)) hif2 ();

    assign hif2.start   = hif.start;
    assign hif2.abort   = hif.abort;
    assign hif2.pattern = hif.pattern;
    assign hif2.len     = hif.len;

    logic       m_reset, x_out, m_reset2, x_out2, f_in, f_rand, mach_q;
    logic [2:0] s_in;
    int         fmode;

    // Machine stand-in: F is x delayed by one clock, cleared while held in reset.
    always_ff @(posedge clk) mach_q <= m_reset ? 1'b0 : x_out;
    assign f_in = (fmode == 0) ? mach_q : (fmode == 2) ? 1'b1 : f_rand;

    machine_seq_ctrl #(.N(8), .LW(4), .CW(4), .MAX_STATE(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .host(hif.slave),
        .m_reset_o(m_reset), .x_out_o(x_out), .f_in_i(f_in), .s_in_i(s_in)
    );

    machine_seq_ctrl #(.N(8), .LW(4), .CW(2), .MAX_STATE(5)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .host(hif2.slave),
        .m_reset_o(m_reset2), .x_out_o(x_out2), .f_in_i(f_in), .s_in_i(s_in)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction, checked cycle by cycle. Cycle c=1 is the cycle after acceptance.
    task automatic run(input logic [7:0] pat, input logic [3:0] len, input int mode,
                       input int abort_c, input int poke_c, input int bad_c,
                       output logic [7:0] m4, output logic [3:0] c4, output logic [1:0] c2);
        int         le, ones;
        logic [7:0] em;
        bit         exp_err;
        le      = (len > 4'd8) ? 8 : int'(len);
        em      = '0;
        exp_err = 1'b0;
        m4      = '0;
        c4      = '0;
        c2      = '0;
        fmode   = mode;
        @(negedge clk);
        hif.pattern = pat;
        hif.len     = len;
        hif.start   = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        for (int c = 1; c <= le + 3; c++) begin
            ones = $countones(em);
            chk("busy", 32'(hif.busy), 32'd1);
            chk("done_timing", 32'(hif.done), 32'(c == le + 3));
            if (c == 1) begin
                chk("clr_mreset", 32'(m_reset), 32'd1);
                chk("err_cleared", 32'(hif.state_err), 32'd0);
            end
            if (c >= 2 && c <= le + 1) begin
                chk("x_out", 32'(x_out), 32'(pat[c-2]));
                chk("x_out_cw2", 32'(x_out2), 32'(pat[c-2]));
                chk("run_mreset", 32'(m_reset), 32'd0);
            end
            if (c == abort_c) begin
                hif.abort = 1'b1;
                @(negedge clk);
                hif.abort = 1'b0;
                s_in      = 3'd0;
                chk("abort_busy", 32'(hif.busy), 32'd0);
                chk("abort_mreset", 32'(m_reset), 32'd1);
                chk("abort_mask", 32'(hif.hit_mask), 32'(em));
                chk("abort_count", 32'(hif.hit_count), 32'(ones));
                @(negedge clk);
                chk("abort_no_done", 32'(hif.done | hif2.done), 32'd0);
                return;
            end
            if (c == poke_c) begin
                hif.start   = 1'b1;
                hif.pattern = ~pat;
                hif.len     = 4'd1;
            end
            if (c == poke_c + 1) hif.start = 1'b0;
            s_in = (c == bad_c) ? 3'd7 : 3'd0;
            if (ChkEn && c == bad_c && c >= 2 && c <= le + 2) exp_err = 1'b1;
            if (c == le + 3) begin
                chk("final_mask", 32'(hif.hit_mask), 32'(em));
                chk("final_count", 32'(hif.hit_count), 32'((ones > 15) ? 15 : ones));
                chk("final_mask_cw2", 32'(hif2.hit_mask), 32'(em));
                chk("final_count_cw2", 32'(hif2.hit_count), 32'((ones > 3) ? 3 : ones));
                chk("done_cw2", 32'(hif2.done), 32'd1);
                chk("state_err", 32'(hif.state_err), 32'(exp_err));
                m4 = hif.hit_mask;
                c4 = hif.hit_count;
                c2 = hif2.hit_count;
            end
            f_rand = 1'($urandom);
            #1;
            if (c >= 3 && c <= le + 2) em[c-3] = f_in;
            @(negedge clk);
        end
        s_in = 3'd0;
        chk("idle_busy", 32'(hif.busy), 32'd0);
        chk("idle_done", 32'(hif.done), 32'd0);
        chk("idle_mreset", 32'(m_reset), 32'd1);
        @(negedge clk);
        chk("hold_mask", 32'(hif.hit_mask), 32'(em));
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        int         mode;
        logic [7:0] emask;
        logic [3:0] ecnt;
        logic [1:0] ecnt2;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] m4;
    logic [3:0] c4;
    logic [1:0] c2;
    int         le, ab, pk, bd;

    initial begin
        // F=x delayed: mask is the applied bits; mode 2 holds F at 1.
        tbl[0] = '{8'h0B, 4'd4,  0, 8'h0B, 4'd3, 2'd3};
        tbl[1] = '{8'hA5, 4'd15, 0, 8'hA5, 4'd4, 2'd3};
        tbl[2] = '{8'hFF, 4'd8,  2, 8'hFF, 4'd8, 2'd3};
        tbl[3] = '{8'h3C, 4'd3,  2, 8'h07, 4'd3, 2'd3};
        tbl[4] = '{8'h00, 4'd8,  0, 8'h00, 4'd0, 2'd0};
        tbl[5] = '{8'h81, 4'd1,  0, 8'h01, 4'd1, 2'd1};
        tbl[6] = '{8'hC3, 4'd2,  0, 8'h03, 4'd2, 2'd2};

        rst_n       = 1'b0;
        hif.start   = 1'b0;
        hif.abort   = 1'b0;
        hif.pattern = '0;
        hif.len     = '0;
        s_in        = 3'd0;
        f_rand      = 1'b0;
        fmode       = 1;
        repeat (2) @(negedge clk);
        chk("rst_mreset", 32'(m_reset), 32'd1);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_done", 32'(hif.done), 32'd0);
        chk("rst_mask", 32'(hif.hit_mask), 32'd0);
        chk("rst_count", 32'(hif.hit_count), 32'd0);
        chk("rst_err", 32'(hif.state_err), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].pat, tbl[i].len, tbl[i].mode, 0, 0, 0, m4, c4, c2);
            chk("tbl_mask", 32'(m4), 32'(tbl[i].emask));
            chk("tbl_count", 32'(c4), 32'(tbl[i].ecnt));
            chk("tbl_count_cw2", 32'(c2), 32'(tbl[i].ecnt2));
        end

        // len=0 is ignored.
        @(negedge clk);
        hif.len   = 4'd0;
        hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        chk("zero_len_busy", 32'(hif.busy), 32'd0);
        @(negedge clk);
        chk("zero_len_mreset", 32'(m_reset), 32'd1);

        // abort and start together in IDLE: nothing starts.
        hif.len   = 4'd3;
        hif.start = 1'b1;
        hif.abort = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        hif.abort = 1'b0;
        chk("abort_start_busy", 32'(hif.busy), 32'd0);
        @(negedge clk);
        chk("abort_start_busy2", 32'(hif.busy), 32'd0);

        run(8'hFF, 4'd6, 2, 4, 0, 0, m4, c4, c2);   // abort in RUN cycle 2
        run(8'h96, 4'd8, 1, 0, 3, 0, m4, c4, c2);   // start pulsed while busy
        run(8'h5A, 4'd5, 1, 0, 0, 3, m4, c4, c2);   // illegal S in RUN
        chk("err_sticky", 32'(hif.state_err), 32'(ChkEn));
        run(8'h33, 4'd3, 1, 0, 0, 0, m4, c4, c2);   // next start clears the flag

        // Asynchronous reset mid-RUN.
        fmode       = 2;
        hif.pattern = 8'hFF;
        hif.len     = 4'd8;
        hif.start   = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_mreset", 32'(m_reset), 32'd1);
        chk("midrun_rst_x", 32'(x_out), 32'd0);
        chk("midrun_rst_busy", 32'(hif.busy), 32'd0);
        chk("midrun_rst_count", 32'(hif.hit_count), 32'd0);
        chk("midrun_rst_mask", 32'(hif.hit_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_rst_no_done", 32'(hif.done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ln;
            ln = 4'($urandom_range(1, 15));
            le = (ln > 4'd8) ? 8 : int'(ln);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, le + 2)) : 0;
            pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, le + 1)) : 0;
            bd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, le + 3)) : 0;
            run(8'($urandom), ln, int'($urandom_range(0, 2)), ab, pk, bd, m4, c4, c2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
